online_sub_seq_r4: RTL and testbench

Sequencer for the radix-4 online subtractor core (online_sub_r4, signed 3-bit digits, MSD-first).
- Accepts parallel operands x, y over a valid/ready handshake.
- Clears the core, streams one digit pair per cycle, then zero-pads through the online delay.
- Collects the N+1 result digits into a parallel word and returns it over a second valid/ready handshake.
- Replaces hand-driven testbench sequencing; lets the core sit behind a bus-style interface.

---
 rtl/online_r4_pkg.sv | 18 +
 rtl/digit_shreg_r4.sv | 25 ++
 rtl/online_sub_seq_r4.sv | 127 ++++++++++++
 tb/tb_online_sub_seq_r4.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/online_r4_pkg.sv
// Shared definitions for the radix-4 online digit datapath: digit width,
// default operand length / online delay, and the sequencer state encoding.
package online_r4_pkg;

   localparam int DIGIT_C       = 3;
   localparam int N_DEFAULT     = 6;
   localparam int DELAY_DEFAULT = 2;

   typedef logic signed [DIGIT_C-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      STREAM,
      DONE
   } state_t;

endpackage

// File: rtl/digit_shreg_r4.sv
// Digit-wide shift register: parallel load, shift left by one digit per
// enabled cycle with a new digit entering on the LSB side.
module digit_shreg_r4 #(
   parameter int DIGITS = 6,
   parameter int C      = 3
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DIGITS*C-1:0]   din,
   input  logic [C-1:0]          sin,
   output logic [DIGITS*C-1:0]   q
);

   always_ff @(posedge clk) begin
      if (clear)
         q <= '0;
      else if (load)
         q <= din;
      else if (shift)
         q <= {q[DIGITS*C-C-1:0], sin};
   end

endmodule

// File: rtl/online_sub_seq_r4.sv
// Sequencer wrapping the radix-4 online subtractor core behind two
// valid/ready handshakes: operands in, parallel N+1 digit result out.
module online_sub_seq_r4
   import online_r4_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int C     = DIGIT_C,
   parameter int DELAY = DELAY_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*C-1:0]       in_x,
   input  logic [N*C-1:0]       in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [(N+1)*C-1:0]   out_z,
   output logic                 busy,
   output logic                 core_reset,
   output logic                 core_en,
   output logic [C-1:0]         core_xi,
   output logic [C-1:0]         core_yi,
   input  logic [C-1:0]         core_zi
);

   localparam int CW = $clog2(N+DELAY+1);
   localparam logic [CW-1:0] K_LAST = CW'(N+DELAY-1);
   localparam logic [CW-1:0] K_CAP  = CW'(DELAY-1);

   state_t              state, state_nxt;
   logic [CW-1:0]       k;
   logic                load, shift_op, capture;
   logic [N*C-1:0]      xq, yq;
   logic [(N+1)*C-1:0]  zq;

   assign load     = (state == IDLE) && in_valid;
   assign shift_op = (state == STREAM);
   // The first DELAY-1 core outputs precede the online delay and are dropped.
   assign capture  = (state == STREAM) && (k >= K_CAP);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset)
         k <= '0;
      else if (state == CLEAR)
         k <= '0;
      else if (state == STREAM)
         k <= k + CW'(1);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CLEAR;
         CLEAR:   state_nxt = STREAM;
         STREAM:  if (k == K_LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      core_en    = 1'b0;
      core_reset = reset;
      core_xi    = '0;
      core_yi    = '0;
      case (state)
         IDLE:   in_ready = 1'b1;
         CLEAR: begin
            busy       = 1'b1;
            core_reset = 1'b1;
         end
         STREAM: begin
            busy    = 1'b1;
            core_en = 1'b1;
            core_xi = xq[N*C-1 -: C];
            core_yi = yq[N*C-1 -: C];
         end
         DONE:   out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operands shift MSD-first; zero fill supplies the padding digits.
   digit_shreg_r4 #(.DIGITS(N), .C(C)) u_xreg (
      .clk   (clk),
      .clear (1'b0),
      .load  (load),
      .shift (shift_op),
      .din   (in_x),
      .sin   ({C{1'b0}}),
      .q     (xq)
   );

   digit_shreg_r4 #(.DIGITS(N), .C(C)) u_yreg (
      .clk   (clk),
      .clear (1'b0),
      .load  (load),
      .shift (shift_op),
      .din   (in_y),
      .sin   ({C{1'b0}}),
      .q     (yq)
   );

   digit_shreg_r4 #(.DIGITS(N+1), .C(C)) u_zreg (
      .clk   (clk),
      .clear (reset),
      .load  (1'b0),
      .shift (capture),
      .din   ({((N+1)*C){1'b0}}),
      .sin   (core_zi),
      .q     (zq)
   );

   assign out_z = zq;

endmodule

// File: tb/tb_online_sub_seq_r4.sv
// Bench for online_sub_seq_r4 with a stub core whose output digit is a
// known function of the stream position and the digits fed to it.
module tb_online_sub_seq_r4;

   localparam int N = 6, C = 3, DELAY = 2;
   localparam int XW = N*C, ZW = (N+1)*C;

   logic          clk = 1'b0;
   logic          reset, in_valid, out_ready;
   logic [XW-1:0] in_x, in_y;
   logic          in_ready, out_valid, busy, core_reset, core_en;
   logic [ZW-1:0] out_z;
   logic [C-1:0]  core_xi, core_yi, core_zi;

   int total = 0;
   int bad   = 0;
   int mode  = 0;
   logic [7:0] scnt = 8'd0;

   always #5 clk = ~clk;

   online_sub_seq_r4 #(.N(N), .C(C), .DELAY(DELAY)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_z      (out_z),
      .busy       (busy),
      .core_reset (core_reset),
      .core_en    (core_en),
      .core_xi    (core_xi),
      .core_yi    (core_yi),
      .core_zi    (core_zi)
   );

   // Stub core: counts enabled cycles since its last reset.
   always_ff @(posedge clk) begin
      if (core_reset)
         scnt <= 8'd0;
      else if (core_en)
         scnt <= scnt + 8'd1;
   end

   always_comb begin
      core_zi = scnt[C-1:0];
      if (mode == 1)
         core_zi = core_xi + core_yi + scnt[C-1:0];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [C-1:0] dig(input logic [XW-1:0] v, input int k);
      if (k >= N) return '0;
      return v[(N-1-k)*C +: C];
   endfunction

   // Result digit j (MSD first) is the core output at stream step j+DELAY-1.
   function automatic logic [ZW-1:0] model(input logic [XW-1:0] x, input logic [XW-1:0] y, input int md);
      logic [ZW-1:0] z;
      logic [C-1:0]  d;
      int            k;
      z = '0;
      for (int j = 0; j <= N; j++) begin
         k = j + DELAY - 1;
         if (md == 0) d = C'(k);
         else         d = dig(x, k) + dig(y, k) + C'(k);
         z[(N-j)*C +: C] = d;
      end
      return z;
   endfunction

   task automatic run(input logic [XW-1:0] x, input logic [XW-1:0] y, input int hold, input bit keep);
      logic [ZW-1:0] exp_z;
      exp_z     = model(x, y, mode);
      in_x      = x;
      in_y      = y;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      chk("in_ready_idle", 64'(in_ready), 64'(1));
      cyc();
      in_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
      in_x     = XW'($urandom);
      in_y     = XW'($urandom);
      chk("clear_ctl", 64'({busy, core_reset, core_en, in_ready}), 64'(4'b1100));
      for (int k = 0; k < N + DELAY; k++) begin
         cyc();
         if (!keep) in_valid = 1'($urandom_range(0, 1));
         chk("stream_ctl", 64'({busy, core_en, core_reset, out_valid, in_ready}), 64'(5'b11000));
         chk("core_xi", 64'(core_xi), 64'(dig(x, k)));
         chk("core_yi", 64'(core_yi), 64'(dig(y, k)));
      end
      cyc();
      chk("done_valid", 64'({out_valid, in_ready, busy}), 64'(3'b100));
      chk("out_z", 64'(out_z), 64'(exp_z));
      for (int h = 0; h < hold; h++) begin
         cyc();
         chk("hold_valid", 64'({out_valid, in_ready}), 64'(2'b10));
         chk("hold_z", 64'(out_z), 64'(exp_z));
      end
      out_ready = 1'b1;
      in_valid  = keep;
      cyc();
      out_ready = 1'b0;
      chk("after_hs", 64'({out_valid, in_ready, busy}), 64'(3'b010));
      chk("after_hs_z", 64'(out_z), 64'(exp_z));
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_x      = '0;
      in_y      = '0;
      repeat (3) cyc();
      chk("rst_core_reset", 64'(core_reset), 64'(1));
      reset = 1'b0;
      cyc();
      chk("rst_state", 64'({in_ready, out_valid, busy, core_en, core_reset}), 64'(5'b10000));
      chk("rst_z", 64'(out_z), 64'(0));
      chk("rst_digits", 64'({core_xi, core_yi}), 64'(0));

      // Counting stub: known constant result.
      mode = 0;
      run(18'o123456, 18'o654321, 0, 1'b0);
      chk("t1_const_z", 64'(out_z), 64'(21'o1234567));

      // Data-dependent stub with consumer stall.
      mode = 1;
      run(XW'($urandom), XW'($urandom), 5, 1'b0);

      // Reset during STREAM at k=3.
      in_x     = XW'($urandom);
      in_y     = XW'($urandom);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (4) cyc();
      chk("mid_in_stream", 64'({busy, core_en}), 64'(2'b11));
      reset = 1'b1;
      cyc();
      chk("abort_ctl", 64'({in_ready, out_valid, busy, core_en, core_reset}), 64'(5'b10001));
      chk("abort_z", 64'(out_z), 64'(0));
      reset = 1'b0;
      cyc();
      chk("abort_release", 64'(core_reset), 64'(0));
      run(XW'($urandom), XW'($urandom), 1, 1'b0);

      // Back-to-back with in_valid held high.
      run(XW'($urandom), XW'($urandom), 0, 1'b1);
      run(XW'($urandom), XW'($urandom), 2, 1'b1);
      in_valid = 1'b0;

      // Random operands, random stalls, stray in_valid pulses mid-run.
      for (int i = 0; i < 6; i++)
         run(XW'($urandom), XW'($urandom), int'($urandom_range(0, 3)), 1'b0);
      in_valid = 1'b0;
      cyc();
      chk("final_idle", 64'({in_ready, busy, out_valid}), 64'(3'b100));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
